uart_rx_oversampler: RTL
========================

# uart_rx_oversampler

Parametrised oversampling front end for the UART receiver. It synchronises the raw serial line and takes NUM_SAMPLES samples centred on the middle of each bit period, with positions set by the runtime Prescale and the shared edge counter. It resolves the bit by majority vote and emits a one-cycle result strobe with a noise flag. It sits between the RX pin and the RX FSM / deserializer / parity and stop checkers, and replaces the fixed three-sample sampler.

## Interface
- PRESCALE_W, 6: width of Prescale and edge_cnt; supports oversampling ratios up to 2^PRESCALE_W-1.
- NUM_SAMPLES, 3: samples per bit; must be odd, 1..7; elaboration fails otherwise.
- SYNC_STAGES, 2: RX_IN synchroniser depth, 2..3.

- CLK  in  1  oversampling clock (Prescale × baud).
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  raw serial line, asynchronous to CLK.
- Prescale  in  PRESCALE_W  oversampling ratio; quasi-static; changed only while dat_samp_en=0.
- dat_samp_en  in  1  sampling enable from the RX FSM.
- edge_cnt  in  PRESCALE_W  position within the current bit, 0..Prescale-1, from the edge counter.
- sampled_bit  out  1  majority-voted bit; held until the next result.
- samp_valid  out  1  one-cycle pulse; sampled_bit and noise_err were updated at this edge.
- noise_err  out  1  samples of the last resolved bit were not unanimous; held until the next result.
- cfg_err  out  1  current Prescale cannot fit the sampling window; registered.

## Operation
- Synchroniser: SYNC_STAGES flops, all reset to 1 (idle mark). Every sample reads the last stage, rx_s.
- Window arithmetic, in PRESCALE_W+1 bits with no wrap:
  - C = Prescale>>1, H = (NUM_SAMPLES-1)/2.
  - start = C-H, last = C+H.
  - Window is legal iff C >= H and last <= Prescale-1.
  - cfg_err <= ~legal every cycle.
- Sample counter idx, range 0..NUM_SAMPLES-1, and ones accumulator ones, width clog2(NUM_SAMPLES+1).
- States:
  - IDLE: idx=0, ones=0.
  - COLLECT: waiting for sample idx.
- Transitions:
  - IDLE→COLLECT when dat_samp_en=1, legal=1 and edge_cnt==start. At that edge sample 0 is taken (ones<=rx_s) and idx<=1. If NUM_SAMPLES=1, the edge resolves immediately and the block stays in IDLE.
  - In COLLECT, if edge_cnt==start+idx: ones<=ones+rx_s, idx<=idx+1.
  - In COLLECT, if idx==NUM_SAMPLES-1 at a matching edge: resolve with total = ones+rx_s.
    - sampled_bit <= (total > H).
    - noise_err <= (total != 0 && total != NUM_SAMPLES).
    - samp_valid <= 1 for that one cycle; return to IDLE.
  - Each position is sampled at most once: if edge_cnt stalls on a matching value, extra cycles are ignored because idx has advanced.
- Abort to IDLE, discarding the partial result with no samp_valid and sampled_bit/noise_err unchanged, when any of these holds:
  - dat_samp_en=0;
  - edge_cnt==0 while in COLLECT (new bit started);
  - edge_cnt > start+idx in COLLECT (sample position skipped).
- Aborts take priority over sample capture in the same cycle.
- No result is ever produced while cfg_err=1.
- Reset mid-operation: all state returns to IDLE immediately, outputs go to reset values, synchroniser returns to 1.

## Timing
- Reset values:
  - sampled_bit=1, samp_valid=0, noise_err=0, cfg_err=0.
  - Synchroniser flops=1, idx=0, ones=0.
- RX_IN to rx_s: SYNC_STAGES cycles. The edge counter owner compensates for this; the block does not.
- Result latency: samp_valid is high in the cycle immediately after the CLK edge at which edge_cnt==last. sampled_bit and noise_err change at that same edge.
- samp_valid is never high in two consecutive cycles. At most one pulse per bit period.
- cfg_err follows a Prescale change one cycle later.

## Test plan
- Prescale=8, N=3, RX_IN=1 steady, edge_cnt 0..7 repeating → samples at edge_cnt 3,4,5; samp_valid after edge 5 each bit; sampled_bit=1, noise_err=0.
- Prescale=16, N=5, rx_s pattern 1,0,1,0,0 at edge_cnt 6..10 → sampled_bit=0, noise_err=1; pattern 1,1,0,1,1 → sampled_bit=1, noise_err=1.
- Prescale=2, N=3 → cfg_err=1 one cycle later, no samp_valid over 10 bit periods. Prescale=4, N=3 → cfg_err=0, samples at edge_cnt 1,2,3.
- Prescale=8, N=3: dat_samp_en dropped at edge_cnt 4 → no samp_valid that bit, sampled_bit keeps its old value. edge_cnt held at 4 for 3 cycles → 4 counted once, correct result at edge 5.
- RST asserted at edge_cnt 4 mid-window → sampled_bit=1, noise_err=0, samp_valid=0 immediately. After release, the first bit resolves normally with no stale sample.
- N=1, Prescale=8 → single sample at edge_cnt 4; samp_valid after that edge; noise_err always 0.

Source files
------------

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
// Oversampling front end for the UART receiver. Synchronises RX_IN, takes
// NUM_SAMPLES samples centred on the middle of each bit period (positions
// derived from Prescale and the shared edge counter), majority-votes them and
// emits a one-cycle result strobe together with a noise flag.

module uart_rx_oversampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  samp_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);

  localparam int WW     = PRESCALE_W + 1;
  localparam int H      = (NUM_SAMPLES - 1) / 2;
  localparam int IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int ONES_W = $clog2(NUM_SAMPLES + 1);

  // Reject sample counts that have no clean majority or exceed the supported range
  if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_samples
    $error("uart_rx_oversampler: NUM_SAMPLES must be odd and in 1..7");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync
    $error("uart_rx_oversampler: SYNC_STAGES must be 2 or 3");
  end

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_nextIdx;
  logic [ONES_W-1:0]   r_ones;
  logic [ONES_W-1:0]   w_nextOnes;
  logic                r_done;
  logic [SYNC_STAGES-1:0] r_sync;

  logic                w_rxS;
  logic [WW-1:0]       w_prescale;
  logic [WW-1:0]       w_center;
  logic [WW-1:0]       w_start;
  logic [WW-1:0]       w_last;
  logic [WW-1:0]       w_target;
  logic [WW-1:0]       w_edge;
  logic                w_legal;
  logic                w_isLast;
  logic                w_abort;
  logic                w_take;
  logic                w_resolve;
  logic [ONES_W-1:0]   w_total;
  logic                w_bit;
  logic                w_noise;

  // Window arithmetic is done one bit wider than Prescale so nothing wraps
  assign w_rxS      = r_sync[SYNC_STAGES-1];
  assign w_prescale = {1'b0, Prescale};
  assign w_edge     = {1'b0, edge_cnt};
  assign w_center   = w_prescale >> 1;
  assign w_start    = w_center - WW'(H);
  assign w_last     = w_center + WW'(H);
  assign w_legal    = (w_center >= WW'(H)) && (w_last < w_prescale);
  assign w_target   = w_start + WW'(r_idx);
  assign w_isLast   = (r_idx == IDX_W'(NUM_SAMPLES - 1));

  // A partial bit is dropped when sampling is disabled, the window becomes
  // illegal, a new bit starts, or the counter jumped past the next position
  assign w_abort = (r_state == S_COLLECT) &&
                   (!dat_samp_en || !w_legal || (w_edge == '0) || (w_edge > w_target));

  // r_done stops a stalled edge counter from re-triggering a freshly resolved window
  assign w_take  = dat_samp_en && w_legal && (w_edge == w_target) && !w_abort &&
                   !((r_state == S_IDLE) && r_done);

  // Two-flop (or three-flop) synchroniser, idling at mark level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_sync <= '1;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
  end

  // State register: FSM state, sample index, ones accumulator and resolve latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ones  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      r_ones  <= w_nextOnes;
      if (w_resolve)            r_done <= 1'b1;
      else if (w_edge != w_last) r_done <= 1'b0;
    end
  end

  // Next-state logic: aborts and resolutions return to IDLE, captures advance idx
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_nextOnes  = r_ones;
    if (w_abort || w_resolve) begin
      w_nextState = S_IDLE;
      w_nextIdx   = '0;
      w_nextOnes  = '0;
    end else if (w_take) begin
      w_nextState = S_COLLECT;
      w_nextIdx   = r_idx + IDX_W'(1);
      w_nextOnes  = w_total;
    end
  end

  // Output decode: the last capture of a window produces the vote and noise flag
  always_comb begin
    w_total   = r_ones + ONES_W'(w_rxS);
    w_resolve = w_take && w_isLast;
    w_bit     = (w_total > ONES_W'(H));
    w_noise   = (w_total != '0) && (w_total != ONES_W'(NUM_SAMPLES));
  end

  // Registered results: held between strobes; cfg_err tracks the window check
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit <= 1'b1;
      samp_valid  <= 1'b0;
      noise_err   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      samp_valid <= w_resolve;
      cfg_err    <= ~w_legal;
      if (w_resolve) begin
        sampled_bit <= w_bit;
        noise_err   <= w_noise;
      end
    end
  end

endmodule
